// File: rtl/seg7_scan_reader.sv
`default_nettype none
// ============================================================================
// seg7_scan_reader - reads back a multiplexed common-anode 7-segment bus and
//                    reconstructs nibble, DP and status for every digit.
// Rev 1.0
// ============================================================================
module seg7_scan_reader #(
   parameter int NUM_DIGITS    = 6,
   parameter int STABLE_CYCLES = 4,
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [7:0]              seg_i,
   input  logic [NUM_DIGITS-1:0]   an_i,
   output logic [4*NUM_DIGITS-1:0] hex_o,
   output logic [NUM_DIGITS-1:0]   dp_o,
   output logic [NUM_DIGITS-1:0]   valid_o,
   output logic [NUM_DIGITS-1:0]   err_o,
   output logic                    upd_o,
   output logic [IDX_W-1:0]        upd_idx_o
);

   localparam int                CNT_W   = $clog2(STABLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
   localparam logic [6:0]       BLANK   = 7'h7F;

   typedef enum logic [0:0] {ST_ACQ = 1'b0, ST_LOCKED = 1'b1} state_t;

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [NUM_DIGITS+7:0]   prv_q, prv_d;
   logic [4*NUM_DIGITS-1:0] hex_q, hex_d;
   logic [NUM_DIGITS-1:0]   dp_q, dp_d, valid_q, valid_d, err_q, err_d;
   logic                    upd_q, upd_d;
   logic [IDX_W-1:0]        upd_idx_q, upd_idx_d;

   logic                    equal, legal, commit;
   logic [IDX_W-1:0]        idx;
   logic [4:0]              dec;
   int                      zeros;

   // Inverse of the hex->7seg table; bit 4 flags a table hit.
   function automatic logic [4:0] decode(input logic [6:0] s);
      case (s)
         7'h40:   decode = {1'b1, 4'h0};
         7'h79:   decode = {1'b1, 4'h1};
         7'h24:   decode = {1'b1, 4'h2};
         7'h30:   decode = {1'b1, 4'h3};
         7'h19:   decode = {1'b1, 4'h4};
         7'h12:   decode = {1'b1, 4'h5};
         7'h02:   decode = {1'b1, 4'h6};
         7'h78:   decode = {1'b1, 4'h7};
         7'h00:   decode = {1'b1, 4'h8};
         7'h10:   decode = {1'b1, 4'h9};
         7'h08:   decode = {1'b1, 4'hA};
         7'h03:   decode = {1'b1, 4'hB};
         7'h46:   decode = {1'b1, 4'hC};
         7'h21:   decode = {1'b1, 4'hD};
         7'h06:   decode = {1'b1, 4'hE};
         7'h0E:   decode = {1'b1, 4'hF};
         default: decode = 5'b0_0000;
      endcase
   endfunction

   always_comb begin
      prv_d     = {an_i, seg_i};
      equal     = (prv_d == prv_q);
      zeros     = 0;
      idx       = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (!an_i[i]) begin
            zeros = zeros + 1;
            idx   = IDX_W'(i);
         end
      end
      legal     = (zeros == 1);

      cnt_d     = cnt_q;
      state_d   = state_q;
      hex_d     = hex_q;
      dp_d      = dp_q;
      valid_d   = valid_q;
      err_d     = err_q;
      upd_d     = 1'b0;
      upd_idx_d = upd_idx_q;
      dec       = '0;

      if (!legal)
         cnt_d = '0;
      else if (equal)
         cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
      else
         cnt_d = CNT_W'(1);

      // A changed sample restarts the run even from LOCKED, so a one-cycle
      // stability requirement still commits on the first sample of a run.
      commit = legal && (cnt_d == CNT_MAX) && (state_q == ST_ACQ || !equal);

      if (commit)
         state_d = ST_LOCKED;
      else if (!legal || !equal)
         state_d = ST_ACQ;

      if (commit) begin
         dec       = decode(seg_i[6:0]);
         dp_d[idx] = ~seg_i[7];
         if (dec[4]) begin
            hex_d[4*int'(idx) +: 4] = dec[3:0];
            valid_d[idx]            = 1'b1;
            err_d[idx]              = 1'b0;
         end else if (seg_i[6:0] == BLANK) begin
            valid_d[idx] = 1'b0;
            err_d[idx]   = 1'b0;
         end else begin
            err_d[idx] = 1'b1;
         end
         upd_d     = 1'b1;
         upd_idx_d = idx;
      end
   end

   always_ff @(posedge clk_i) begin
      prv_q <= prv_d;
      if (rst_i) begin
         state_q   <= ST_ACQ;
         cnt_q     <= '0;
         hex_q     <= '0;
         dp_q      <= '0;
         valid_q   <= '0;
         err_q     <= '0;
         upd_q     <= 1'b0;
         upd_idx_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         hex_q     <= hex_d;
         dp_q      <= dp_d;
         valid_q   <= valid_d;
         err_q     <= err_d;
         upd_q     <= upd_d;
         upd_idx_q <= upd_idx_d;
      end
   end

   assign hex_o     = hex_q;
   assign dp_o      = dp_q;
   assign valid_o   = valid_q;
   assign err_o     = err_q;
   assign upd_o     = upd_q;
   assign upd_idx_o = upd_idx_q;

endmodule
`default_nettype wire
